// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: bundles the display, CPU and RAM-side signals of the VRAM arbiter.
//   slave  modport: the arbiter side (takes requests, drives grants and RAM controls).
//   master modport: the environment side (display fetcher, CPU and the RAM itself).
interface vram_arbiter_if;
  // Display fetch port
  logic        disp_req;
  logic [13:0] disp_addr;
  logic        disp_grant;
  logic        disp_valid;
  logic [15:0] disp_data;
  // CPU write port (byte address)
  logic        cpu_wr_req;
  logic [15:0] cpu_wr_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_wr_busy;
  // CPU read port (byte address)
  logic        cpu_rd_req;
  logic [15:0] cpu_rd_addr;
  logic        cpu_rd_busy;
  logic        cpu_rd_valid;
  logic [7:0]  cpu_rd_data;
  // Dropped-strobe flag
  logic        overflow;
  logic        overflow_clr;
  // Single-port RAM controls
  logic [13:0] ram_addr;
  logic [15:0] ram_data_in;
  logic [3:0]  ram_maskwren;
  logic        ram_wren;
  logic [15:0] ram_data_out;

  modport slave (
    input  disp_req, disp_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    input  cpu_rd_req, cpu_rd_addr, overflow_clr, ram_data_out,
    output disp_grant, disp_valid, disp_data, cpu_wr_busy, cpu_rd_busy,
    output cpu_rd_valid, cpu_rd_data, overflow,
    output ram_addr, ram_data_in, ram_maskwren, ram_wren
  );

  modport master (
    output disp_req, disp_addr, cpu_wr_req, cpu_wr_addr, cpu_wr_data,
    output cpu_rd_req, cpu_rd_addr, overflow_clr, ram_data_out,
    input  disp_grant, disp_valid, disp_data, cpu_wr_busy, cpu_rd_busy,
    input  cpu_rd_valid, cpu_rd_data, overflow,
    input  ram_addr, ram_data_in, ram_maskwren, ram_wren
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port 16-bit VRAM between a display fetcher and a CPU byte
// port. One access per cycle; display has priority, then CPU write, then CPU read, except that
// after STARVE_LIMIT consecutive display grants with a CPU access pending the CPU wins a cycle.
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   bus      - vram_arbiter_if.slave: display req/grant/data, CPU write/read strobes with
//              one-deep buffers and busy flags, sticky overflow, RAM address/data/mask/wren.
module vram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic             clk,
  input logic             reset_n,
  vram_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StDisp, StWr, StRd} grant_e;

  grant_e      grant, last_grant_q;
  logic        wr_full_q, wr_full_d;
  logic [14:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        rd_full_q, rd_full_d;
  logic [14:0] rd_addr_q, rd_addr_d;
  logic        rd_hi_q, rd_hi_d;
  logic [3:0]  starve_ctr_q, starve_ctr_d;
  logic        overflow_q, overflow_d;
  logic        cpu_pending, starve;
  logic        wr_capture, rd_capture;

  // Address bit 15 selects nothing in a 32 KiB space.
  logic unused_addr_msb;
  assign unused_addr_msb = bus.cpu_wr_addr[15] ^ bus.cpu_rd_addr[15];

  assign cpu_pending = wr_full_q | rd_full_q;
  assign starve      = cpu_pending && (starve_ctr_q == 4'(STARVE_LIMIT));

  // Grant selection; gated by reset_n so nothing reaches the RAM while reset is held.
  always_comb begin
    grant = StIdle;
    if (reset_n) begin
      if (bus.disp_req && !starve) grant = StDisp;
      else if (wr_full_q)          grant = StWr;
      else if (rd_full_q)          grant = StRd;
    end
  end

  // RAM controls and buffer/counter next state
  always_comb begin
    bus.disp_grant   = (grant == StDisp);
    bus.ram_addr     = '0;
    bus.ram_data_in  = '0;
    bus.ram_maskwren = '0;
    bus.ram_wren     = 1'b0;
    unique case (grant)
      StDisp: bus.ram_addr = bus.disp_addr;
      StWr: begin
        bus.ram_addr     = wr_addr_q[14:1];
        bus.ram_data_in  = {wr_data_q, wr_data_q};
        bus.ram_maskwren = wr_addr_q[0] ? 4'b1100 : 4'b0011;
        bus.ram_wren     = 1'b1;
      end
      StRd:    bus.ram_addr = rd_addr_q[14:1];
      default: ;
    endcase

    // A strobe fits if the buffer is empty or is draining this very cycle.
    wr_capture = bus.cpu_wr_req && (!wr_full_q || grant == StWr);
    rd_capture = bus.cpu_rd_req && (!rd_full_q || grant == StRd);

    wr_full_d = wr_capture ? 1'b1 : (wr_full_q && grant != StWr);
    wr_addr_d = wr_capture ? bus.cpu_wr_addr[14:0] : wr_addr_q;
    wr_data_d = wr_capture ? bus.cpu_wr_data : wr_data_q;
    rd_full_d = rd_capture ? 1'b1 : (rd_full_q && grant != StRd);
    rd_addr_d = rd_capture ? bus.cpu_rd_addr[14:0] : rd_addr_q;
    // Byte lane latched at grant time: the buffer may be refilled before data returns.
    rd_hi_d   = (grant == StRd) ? rd_addr_q[0] : rd_hi_q;

    // Setting wins over clearing so a drop coincident with a clear is not lost.
    overflow_d = (overflow_q && !bus.overflow_clr) ||
                 (bus.cpu_wr_req && !wr_capture) || (bus.cpu_rd_req && !rd_capture);

    if (!cpu_pending || grant == StWr || grant == StRd) starve_ctr_d = '0;
    else if (grant == StDisp)                            starve_ctr_d = starve_ctr_q + 4'd1;
    else                                                 starve_ctr_d = starve_ctr_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= StIdle;
      wr_full_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      rd_full_q    <= 1'b0;
      rd_addr_q    <= '0;
      rd_hi_q      <= 1'b0;
      starve_ctr_q <= '0;
      overflow_q   <= 1'b0;
    end else begin
      last_grant_q <= grant;
      wr_full_q    <= wr_full_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      rd_full_q    <= rd_full_d;
      rd_addr_q    <= rd_addr_d;
      rd_hi_q      <= rd_hi_d;
      starve_ctr_q <= starve_ctr_d;
      overflow_q   <= overflow_d;
    end
  end

  // Returned data follows the registered RAM output one cycle after the grant.
  always_comb begin
    bus.disp_valid   = (last_grant_q == StDisp);
    bus.disp_data    = bus.disp_valid ? bus.ram_data_out : '0;
    bus.cpu_rd_valid = (last_grant_q == StRd);
    bus.cpu_rd_data  = '0;
    if (bus.cpu_rd_valid) begin
      bus.cpu_rd_data = rd_hi_q ? bus.ram_data_out[15:8] : bus.ram_data_out[7:0];
    end
    bus.cpu_wr_busy  = wr_full_q;
    bus.cpu_rd_busy  = rd_full_q;
    bus.overflow     = overflow_q;
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;
  logic clk = 1'b0;
  logic reset_n;
  int   passed = 0;
  int   total  = 0;
  logic [15:0] mem [16384];

  vram_arbiter_if bus ();

  vram_arbiter #(.STARVE_LIMIT(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  // Registered-output single-port RAM with nibble write mask
  always @(posedge clk) begin
    if (bus.ram_wren) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.ram_maskwren[i]) mem[bus.ram_addr][i*4 +: 4] <= bus.ram_data_in[i*4 +: 4];
      end
    end
    bus.ram_data_out <= mem[bus.ram_addr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'h0000;
    mem[14'h123] = 16'hBEEF;
    reset_n          = 1'b0;
    bus.disp_req     = 1'b0;
    bus.disp_addr    = '0;
    bus.cpu_wr_req   = 1'b0;
    bus.cpu_wr_addr  = '0;
    bus.cpu_wr_data  = '0;
    bus.cpu_rd_req   = 1'b0;
    bus.cpu_rd_addr  = '0;
    bus.overflow_clr = 1'b0;
    #1;
    chk("rst_wr_busy", 32'(bus.cpu_wr_busy), 0);
    chk("rst_rd_busy", 32'(bus.cpu_rd_busy), 0);
    chk("rst_disp_valid", 32'(bus.disp_valid), 0);
    chk("rst_rd_valid", 32'(bus.cpu_rd_valid), 0);
    chk("rst_overflow", 32'(bus.overflow), 0);
    chk("rst_wren", 32'(bus.ram_wren), 0);
    tick();
    tick();
    reset_n = 1'b1;

    // Byte write to odd address lands in high lane
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0003; bus.cpu_wr_data = 8'h5A;
    tick();
    bus.cpu_wr_req = 1'b0;
    chk("w1_busy", 32'(bus.cpu_wr_busy), 1);
    chk("w1_wren", 32'(bus.ram_wren), 1);
    chk("w1_addr", 32'(bus.ram_addr), 1);
    chk("w1_mask", 32'(bus.ram_maskwren), 32'b1100);
    chk("w1_data", 32'(bus.ram_data_in), 32'h5A5A);
    chk("w1_dgrant", 32'(bus.disp_grant), 0);
    tick();
    chk("w1_busy_clr", 32'(bus.cpu_wr_busy), 0);
    chk("w1_idle_wren", 32'(bus.ram_wren), 0);
    chk("w1_idle_addr", 32'(bus.ram_addr), 0);
    chk("w1_idle_mask", 32'(bus.ram_maskwren), 0);

    // Write and read of same address strobed together: write first
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0010; bus.cpu_wr_data = 8'hA5;
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 16'h0010;
    tick();
    bus.cpu_wr_req = 1'b0; bus.cpu_rd_req = 1'b0;
    chk("raw_wren", 32'(bus.ram_wren), 1);
    chk("raw_waddr", 32'(bus.ram_addr), 8);
    chk("raw_mask", 32'(bus.ram_maskwren), 32'b0011);
    chk("raw_rbusy", 32'(bus.cpu_rd_busy), 1);
    tick();
    chk("raw_rd_wren", 32'(bus.ram_wren), 0);
    chk("raw_rd_addr", 32'(bus.ram_addr), 8);
    chk("raw_wbusy", 32'(bus.cpu_wr_busy), 0);
    chk("raw_rvalid_early", 32'(bus.cpu_rd_valid), 0);
    tick();
    chk("raw_rvalid", 32'(bus.cpu_rd_valid), 1);
    chk("raw_rdata", 32'(bus.cpu_rd_data), 32'hA5);
    chk("raw_rbusy_clr", 32'(bus.cpu_rd_busy), 0);
    tick();
    chk("raw_rvalid_pulse", 32'(bus.cpu_rd_valid), 0);

    // Read of odd byte returns high lane
    bus.cpu_rd_req = 1'b1; bus.cpu_rd_addr = 16'h8003;
    tick();
    bus.cpu_rd_req = 1'b0;
    chk("rhi_addr", 32'(bus.ram_addr), 1);
    tick();
    chk("rhi_valid", 32'(bus.cpu_rd_valid), 1);
    chk("rhi_data", 32'(bus.cpu_rd_data), 32'h5A);

    // Starvation: 8 display grants, then one write, then display again
    bus.disp_req = 1'b1; bus.disp_addr = 14'h123;
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0021; bus.cpu_wr_data = 8'h77;
    #1;
    chk("st_first_dgrant", 32'(bus.disp_grant), 1);
    tick();
    bus.cpu_wr_req = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("st_dgrant%0d", k), 32'(bus.disp_grant), 1);
      chk($sformatf("st_nowren%0d", k), 32'(bus.ram_wren), 0);
      tick();
    end
    chk("st_cpu_dgrant", 32'(bus.disp_grant), 0);
    chk("st_cpu_wren", 32'(bus.ram_wren), 1);
    chk("st_cpu_addr", 32'(bus.ram_addr), 32'h10);
    chk("st_cpu_data", 32'(bus.ram_data_in), 32'h7777);
    tick();
    chk("st_resume", 32'(bus.disp_grant), 1);
    chk("st_busy_clr", 32'(bus.cpu_wr_busy), 0);
    chk("st_dvalid_after_wr", 32'(bus.disp_valid), 0);
    tick();
    chk("st_dvalid", 32'(bus.disp_valid), 1);
    chk("st_ddata", 32'(bus.disp_data), 32'hBEEF);

    // Overflow: second strobe while full and not granted is dropped
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0040; bus.cpu_wr_data = 8'h11;
    tick();
    chk("ov_busy", 32'(bus.cpu_wr_busy), 1);
    chk("ov_not_yet", 32'(bus.overflow), 0);
    bus.cpu_wr_data = 8'h22;
    tick();
    bus.cpu_wr_req = 1'b0;
    chk("ov_set", 32'(bus.overflow), 1);
    bus.disp_req = 1'b0;
    #1;
    chk("ov_first_kept", 32'(bus.ram_data_in), 32'h1111);
    chk("ov_first_wren", 32'(bus.ram_wren), 1);
    tick();
    chk("ov_sticky", 32'(bus.overflow), 1);
    chk("ov_busy_clr", 32'(bus.cpu_wr_busy), 0);
    bus.disp_req = 1'b1;
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0042; bus.cpu_wr_data = 8'h44;
    tick();
    bus.cpu_wr_data = 8'h55; bus.overflow_clr = 1'b1;
    tick();
    bus.cpu_wr_req = 1'b0;
    chk("ov_set_beats_clr", 32'(bus.overflow), 1);
    tick();
    bus.overflow_clr = 1'b0;
    chk("ov_cleared", 32'(bus.overflow), 0);
    // Strobe during the grant of a full buffer is captured
    bus.disp_req = 1'b0;
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0044; bus.cpu_wr_data = 8'h66;
    #1;
    chk("cap_grant_data", 32'(bus.ram_data_in), 32'h4444);
    chk("cap_grant_addr", 32'(bus.ram_addr), 32'h21);
    tick();
    bus.cpu_wr_req = 1'b0;
    chk("cap_busy", 32'(bus.cpu_wr_busy), 1);
    chk("cap_data", 32'(bus.ram_data_in), 32'h6666);
    chk("cap_addr", 32'(bus.ram_addr), 32'h22);
    chk("cap_no_ov", 32'(bus.overflow), 0);
    tick();
    chk("cap_busy_clr", 32'(bus.cpu_wr_busy), 0);

    // Reset mid-burst with a write pending
    bus.disp_req = 1'b1;
    bus.cpu_wr_req = 1'b1; bus.cpu_wr_addr = 16'h0060; bus.cpu_wr_data = 8'h99;
    tick();
    bus.cpu_wr_req = 1'b0;
    chk("mr_pending", 32'(bus.cpu_wr_busy), 1);
    reset_n = 1'b0;
    #1;
    chk("mr_busy", 32'(bus.cpu_wr_busy), 0);
    chk("mr_wren", 32'(bus.ram_wren), 0);
    chk("mr_dgrant", 32'(bus.disp_grant), 0);
    chk("mr_dvalid", 32'(bus.disp_valid), 0);
    chk("mr_addr", 32'(bus.ram_addr), 0);
    tick();
    chk("mr_held_wren", 32'(bus.ram_wren), 0);
    reset_n = 1'b1;
    bus.disp_req = 1'b0;
    #1;
    chk("mr_rel_busy", 32'(bus.cpu_wr_busy), 0);
    chk("mr_rel_wren", 32'(bus.ram_wren), 0);
    tick();
    chk("mr_after_wren", 32'(bus.ram_wren), 0);
    chk("mr_mem_untouched", 32'(mem[14'h30]), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 8, range 1-15: consecutive display grants tolerated while a CPU access is pending.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 disp_req  input  1  display fetch request, level, sampled every cycle.
REQ-005 disp_addr  input  14  display word address.
REQ-006 disp_grant  output  1  display access issued to RAM this cycle (combinational).
REQ-007 disp_valid / disp_data  output  1 / 16  fetched word, one cycle after disp_grant.
REQ-008 cpu_wr_req  input  1  single-cycle write strobe.
REQ-009 cpu_wr_addr / cpu_wr_data  input  16 / 8  byte address and data.
REQ-010 cpu_wr_busy  output  1  write buffer occupied.
REQ-011 cpu_rd_req  input  1  single-cycle read strobe.
REQ-012 cpu_rd_addr  input  16  byte address.
REQ-013 cpu_rd_busy  output  1  read buffer occupied.
REQ-014 cpu_rd_valid / cpu_rd_data  output  1 / 8  read byte, one-cycle pulse.
REQ-015 overflow  output  1  sticky: a CPU strobe was dropped.
REQ-016 overflow_clr  input  1  clears overflow.
REQ-017 ram_addr / ram_data_in / ram_maskwren / ram_wren  output  14 / 16 / 4 / 1  single-port RAM controls.
REQ-018 ram_data_out  input  16  RAM read data, registered by RAM, valid cycle after address.

Function
REQ-019 One RAM access per cycle; grant chosen combinationally from disp_req and registered buffer state.
REQ-020 Priority: display > CPU write > CPU read, except REQ-021.
REQ-021 starve_ctr (4 bit) increments each cycle display is granted while either CPU buffer is full, resets to 0 on any CPU grant or when no CPU access is pending; when starve_ctr == STARVE_LIMIT, CPU wins the cycle and disp_grant is 0.
REQ-022 Write buffer: a strobe with buffer empty, or full and being granted this cycle, is captured; otherwise dropped and overflow set. Read buffer: same rule.
REQ-023 A captured strobe is grantable no earlier than the following cycle.
REQ-024 CPU write grant: ram_addr = addr[14:1], ram_data_in = {data,data}, ram_maskwren = 4'b1100 if addr[0] else 4'b0011, ram_wren = 1; addr[15] ignored.
REQ-025 Read/display grant: ram_wren = 0, ram_addr = addr[14:1] or disp_addr.
REQ-026 No grant: ram_wren = 0, ram_addr = 0, ram_maskwren = 0.
REQ-027 Registered last_grant state {IDLE, DISP, WR, RD} records each cycle's grant; DISP -> disp_valid = 1, disp_data = ram_data_out; RD -> cpu_rd_valid = 1, cpu_rd_data = ram_data_out[15:8] if captured addr[0] else [7:0].
REQ-028 Write pending with read pending: write granted first, so read-after-write to same address returns new byte.
REQ-029 overflow set and overflow_clr same cycle: overflow remains 1.
REQ-030 busy outputs = buffer full, registered; deassert cycle after the grant.

Reset
REQ-031 On reset_n low, immediately: buffers empty, busy 0, last_grant IDLE, disp_valid 0, cpu_rd_valid 0, starve_ctr 0, overflow 0; data outputs 0.
REQ-032 Pending accesses at reset are discarded; no RAM write occurs while reset_n low.
REQ-033 First grant possible on the first rising edge after reset_n rises.

Verification
REQ-034 CPU write 0x5A to 0x0003, no display -> next cycle ram_wren=1, ram_addr=1, maskwren=1100, data_in=0x5A5A; busy clears following cycle.
REQ-035 Write 0xA5 to 0x0010 then read 0x0010 strobed same cycle -> write granted before read; cpu_rd_data=0xA5 with cpu_rd_valid one cycle after read grant.
REQ-036 disp_req held high, CPU write pending, STARVE_LIMIT=8 -> eight display grants, then one write grant with disp_grant=0, then display resumes.
REQ-037 Second write strobe while write buffer full and not granted -> dropped, overflow=1 until overflow_clr; first write completes unchanged.
REQ-038 reset_n low mid-burst with write pending -> no ram_wren asserted, all outputs at reset values, buffers empty after release.
